// File: rtl/regfile_wr_arb_if.sv
// Write-back request/grant bundle between the requesters and the register-file write arbiter.
// Latency: none, pure signal grouping.
// Backpressure: per-requester req_rdy grant; the write port itself never stalls.
//
// Signals:
//   hold      : blocks new grants while high
//   req_vld   : per-requester request valid (bit k = requester k)
//   req_addr  : per-requester destination register, slice k = requester k
//   req_data  : per-requester write data, slice k = requester k
//   req_rdy   : per-requester grant, a request is consumed on vld & rdy
//   we/wa/wd  : register-file write port
//   pend_vec  : bit i high while a write to register i is outstanding
// Modports: slave = arbiter view, master = requester / register-file view.
interface regfile_wr_arb_if #(
    parameter int REGS_PTR_W = 5,
    parameter int REGS_NUM   = 32,
    parameter int REG_SIZE   = 32,
    parameter int NUM_REQ    = 3
);
    logic                             hold;
    logic [NUM_REQ-1:0]               req_vld;
    logic [NUM_REQ*REGS_PTR_W-1:0]    req_addr;
    logic [NUM_REQ*REG_SIZE-1:0]      req_data;
    logic [NUM_REQ-1:0]               req_rdy;
    logic                             we;
    logic [REGS_PTR_W-1:0]            wa;
    logic [REG_SIZE-1:0]              wd;
    logic [REGS_NUM-1:0]              pend_vec;

    modport slave (
        input  hold, req_vld, req_addr, req_data,
        output req_rdy, we, wa, wd, pend_vec
    );

    modport master (
        output hold, req_vld, req_addr, req_data,
        input  req_rdy, we, wa, wd, pend_vec
    );
endinterface

// File: rtl/regfile_wr_arb.sv
// Round-robin arbiter funnelling NUM_REQ write-back requests into one register-file write port.
// Latency: grant in cycle T appears as we/wa/wd in cycle T+1 (fixed, 1 cycle).
// Backpressure: one req_rdy per cycle, none while hold or rst; the write port never stalls grants.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : regfile_wr_arb_if.slave (hold, req_vld/addr/data in; req_rdy, we/wa/wd, pend_vec out)
module regfile_wr_arb #(
    parameter int REGS_PTR_W     = 5,
    parameter int REGS_NUM       = 32,
    parameter int REG_SIZE       = 32,
    parameter int NUM_REQ        = 3,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wr_arb_if.slave       bus
);
    // A single requester still needs a 1-bit pointer to keep the code uniform.
    localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [LG_W-1:0]       last_grant;
    logic                  gnt_any;
    logic [LG_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]    gnt_vec;
    logic [REGS_PTR_W-1:0] gnt_addr;
    logic [REG_SIZE-1:0]   gnt_data;
    logic                  gnt_zero;

    logic                  we_q;
    logic [REGS_PTR_W-1:0] wa_q;
    logic [REG_SIZE-1:0]   wd_q;
    logic [REGS_NUM-1:0]   pend;

    // Scan requesters starting one past the last winner; first valid one wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(last_grant) + 1 + i) % NUM_REQ;
            if (!gnt_any && bus.req_vld[idx] && !bus.hold && !rst) begin
                gnt_any = 1'b1;
                gnt_idx = LG_W'(idx);
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign gnt_addr    = bus.req_addr[gnt_idx*REGS_PTR_W +: REGS_PTR_W];
    assign gnt_data    = bus.req_data[gnt_idx*REG_SIZE +: REG_SIZE];
    assign gnt_zero    = (ZERO_HARDWIRED != 0) && (gnt_addr == '0);
    assign bus.req_rdy = gnt_vec;

    // Output stage. A grant to the hardwired-zero register is consumed but
    // produces no write; wa/wd keep their last real write in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= LG_W'(NUM_REQ - 1);
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else if (gnt_any) begin
            last_grant <= gnt_idx;
            if (gnt_zero) begin
                we_q <= 1'b0;
            end else begin
                we_q <= 1'b1;
                wa_q <= gnt_addr;
                wd_q <= gnt_data;
            end
        end else begin
            we_q <= 1'b0;
        end
    end

    assign bus.we = we_q;
    assign bus.wa = wa_q;
    assign bus.wd = wd_q;

    // Outstanding writes: anything still requesting plus the write in flight.
    always_comb begin
        pend = '0;
        for (int i = 0; i < REGS_NUM; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (bus.req_vld[k] &&
                    (bus.req_addr[k*REGS_PTR_W +: REGS_PTR_W] == REGS_PTR_W'(i))) begin
                    pend[i] = 1'b1;
                end
            end
            if (we_q && (wa_q == REGS_PTR_W'(i))) begin
                pend[i] = 1'b1;
            end
        end
        if (ZERO_HARDWIRED != 0) begin
            pend[0] = 1'b0;
        end
    end

    assign bus.pend_vec = pend;
endmodule
